// File: rtl/read_stuff.sv
// Read-back scanner for the vending-machine product table: fetches each slot record
// from a 1-cycle registered memory, checks its ID, streams it out and mirrors it into p0..p4.
module read_stuff #(
    parameter int NUM_SLOTS = 5,
    parameter int REC_W     = 11,
    parameter int ADDR_W    = 3,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [REC_W-1:0]  mem_rdata,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [REC_W-1:0]  rec_data,
    output logic [REC_W-1:0]  p0,
    output logic [REC_W-1:0]  p1,
    output logic [REC_W-1:0]  p2,
    output logic [REC_W-1:0]  p3,
    output logic [REC_W-1:0]  p4,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        PUSH  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SLOTS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [REC_W-1:0]  p_q [8];
    logic [2:0]        slot;
    logic [2:0]        rec_id;

    assign slot      = 3'(idx);
    assign rec_id    = mem_rdata[REC_W-1 -: 3];
    assign dbg_state = state;

    assign p0 = p_q[0];
    assign p1 = p_q[1];
    assign p2 = p_q[2];
    assign p3 = p_q[3];
    assign p4 = p_q[4];

    // Output port handshake: a record transfers on a clock edge where rec_valid and
    // rec_ready are both high; while rec_valid is high and rec_ready is low, rec_data
    // is held unchanged. rec_ready is ignored whenever rec_valid is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            rec_valid <= 1'b0;
            rec_data  <= '0;
            for (int i = 0; i < 8; i++) p_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (start) begin
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        mem_rd   <= 1'b1;
                        mem_addr <= BASE;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                end
                WAIT: begin
                    // A wrong ID is flagged but the record is still stored and streamed.
                    state      <= PUSH;
                    rec_data   <= mem_rdata;
                    p_q[slot]  <= mem_rdata;
                    rec_valid  <= 1'b1;
                    if (rec_id != slot) err <= 1'b1;
                end
                PUSH: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            idx      <= idx + ADDR_W'(1);
                            mem_rd   <= 1'b1;
                            mem_addr <= BASE + idx + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_stuff.sv
// Bench for read_stuff: a base-0 instance and a base-6 instance share one product memory;
// each scan is predicted from a cycle-timeline model built from record durations.
module tb_read_stuff;

    localparam int CMAX = 256;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        sel;
    logic        rec_ready;
    logic [10:0] mem [8];

    logic        start_a, busy_a, done_a, err_a, mem_rd_a, rec_valid_a;
    logic [2:0]  mem_addr_a, dbg_a;
    logic [10:0] rdata_a, rec_data_a, p0_a, p1_a, p2_a, p3_a, p4_a;
    logic        start_b, busy_b, done_b, err_b, mem_rd_b, rec_valid_b;
    logic [2:0]  mem_addr_b, dbg_b;
    logic [10:0] rdata_b, rec_data_b, p0_b, p1_b, p2_b, p3_b, p4_b;

    logic        o_busy, o_done, o_err, o_rd, o_valid;
    logic [2:0]  o_addr;
    logic [10:0] o_data;
    logic [10:0] o_p [5];

    int n_vec, n_err, cur_cycle;

    bit          e_busy [CMAX];
    bit          e_done [CMAX];
    bit          e_rd   [CMAX];
    bit          e_valid[CMAX];
    bit          e_err  [CMAX];
    logic [2:0]  e_addr [CMAX];
    logic [10:0] e_data [CMAX];
    bit          rdy    [CMAX];
    bit          st     [CMAX];
    int          done_c;
    logic [10:0] exp_q[$];
    logic [10:0] exp_p [2][5];
    logic [10:0] scan_p[5];
    bit          err_prev [2];

    read_stuff #(.BASE_ADDR(0)) dut (
        .clock(clock), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
        .err(err_a), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_rdata(rdata_a),
        .rec_valid(rec_valid_a), .rec_ready(rec_ready), .rec_data(rec_data_a),
        .p0(p0_a), .p1(p1_a), .p2(p2_a), .p3(p3_a), .p4(p4_a), .dbg_state(dbg_a)
    );

    read_stuff #(.BASE_ADDR(6)) dut_w (
        .clock(clock), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
        .err(err_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(rdata_b),
        .rec_valid(rec_valid_b), .rec_ready(rec_ready), .rec_data(rec_data_b),
        .p0(p0_b), .p1(p1_b), .p2(p2_b), .p3(p3_b), .p4(p4_b), .dbg_state(dbg_b)
    );

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign o_busy  = sel ? busy_b      : busy_a;
    assign o_done  = sel ? done_b      : done_a;
    assign o_err   = sel ? err_b       : err_a;
    assign o_rd    = sel ? mem_rd_b    : mem_rd_a;
    assign o_addr  = sel ? mem_addr_b  : mem_addr_a;
    assign o_valid = sel ? rec_valid_b : rec_valid_a;
    assign o_data  = sel ? rec_data_b  : rec_data_a;
    assign o_p[0]  = sel ? p0_b : p0_a;
    assign o_p[1]  = sel ? p1_b : p1_a;
    assign o_p[2]  = sel ? p2_b : p2_a;
    assign o_p[3]  = sel ? p3_b : p3_a;
    assign o_p[4]  = sel ? p4_b : p4_a;

    // Clock / reset and the 1-cycle registered product memory
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rd_a) rdata_a <= mem[mem_addr_a];
        if (mem_rd_b) rdata_b <= mem[mem_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cur_cycle, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Timeline model: record k is read one cycle after the previous accept, shows up
    // two cycles later and stays offered until the first cycle with rec_ready high.
    task automatic build_model(input bit wrap);
        int t, c, err_from;
        int base;
        logic [10:0] rec;
        base = wrap ? 6 : 0;
        for (int i = 0; i < CMAX; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_valid[i] = 0;
            e_err[i] = 0; e_addr[i] = 0; e_data[i] = 0;
        end
        exp_q.delete();
        err_from = CMAX;
        t = 1;
        for (int k = 0; k < 5; k++) begin
            rec = mem[(base + k) % 8];
            exp_q.push_back(rec);
            scan_p[k] = rec;
            e_rd[t] = 1;
            e_addr[t] = 3'((base + k) % 8);
            e_busy[t] = 1;
            e_busy[t+1] = 1;
            if (int'(rec[10:8]) != k && t + 2 < err_from) err_from = t + 2;
            c = t + 2;
            while (!rdy[c]) begin
                e_valid[c] = 1; e_data[c] = rec; e_busy[c] = 1;
                c++;
            end
            e_valid[c] = 1; e_data[c] = rec; e_busy[c] = 1;
            t = c + 1;
        end
        done_c = t;
        e_done[t] = 1;
        for (int i = err_from; i < CMAX; i++) e_err[i] = 1;
    endtask

    task automatic run_scan(input bit wrap);
        int inst;
        logic [10:0] want;
        inst = wrap ? 1 : 0;
        sel = wrap;
        build_model(wrap);
        for (int c = 0; c <= done_c + 3; c++) begin
            cur_cycle = c;
            start = (c == 0) ? 1'b1 : st[c];
            rec_ready = (c == 0) ? 1'b0 : rdy[c];
            @(negedge clock);
            if (c == 0) begin
                check("err_held", 32'(o_err), 32'(err_prev[inst]));
                check("idle_busy", 32'(o_busy), 0);
                for (int k = 0; k < 5; k++) check("p_keep", 32'(o_p[k]), 32'(exp_p[inst][k]));
            end else begin
                check("busy", 32'(o_busy), 32'(e_busy[c]));
                check("done", 32'(o_done), 32'(e_done[c]));
                check("mem_rd", 32'(o_rd), 32'(e_rd[c]));
                check("mem_addr", 32'(o_addr), 32'(e_addr[c]));
                check("rec_valid", 32'(o_valid), 32'(e_valid[c]));
                check("err", 32'(o_err), 32'(e_err[c]));
                if (e_valid[c]) check("rec_data", 32'(o_data), 32'(e_data[c]));
                if (o_valid && rec_ready) begin
                    if (exp_q.size() == 0) check("accept_extra", 32'(o_data), 32'h7ff);
                    else begin
                        want = exp_q.pop_front();
                        check("accept", 32'(o_data), 32'(want));
                    end
                end
            end
            tick();
        end
        start = 1'b0;
        rec_ready = 1'b0;
        check("accept_count", 32'(exp_q.size()), 0);
        for (int k = 0; k < 5; k++) begin
            exp_p[inst][k] = scan_p[k];
            check("p_final", 32'(o_p[k]), 32'(scan_p[k]));
        end
        err_prev[inst] = e_err[done_c];
        for (int i = 0; i < CMAX; i++) begin rdy[i] = 1; st[i] = 0; end
    endtask

    task automatic load_table();
        mem[0] = 11'h031; mem[1] = 11'h173; mem[2] = 11'h222; mem[3] = 11'h355; mem[4] = 11'h4B1;
        mem[5] = 11'h000; mem[6] = 11'h000; mem[7] = 11'h000;
    endtask

    task automatic load_random(input bit wrap);
        int a;
        logic [2:0] id;
        for (int k = 0; k < 5; k++) begin
            a = ((wrap ? 6 : 0) + k) % 8;
            id = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(k);
            mem[a] = {id, 8'($urandom_range(0, 255))};
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cur_cycle = 0;
        sel = 0; start = 0; rec_ready = 0; reset_n = 0;
        rdata_a = '0; rdata_b = '0;
        for (int i = 0; i < CMAX; i++) begin rdy[i] = 1; st[i] = 0; end
        for (int j = 0; j < 2; j++) begin
            err_prev[j] = 0;
            for (int k = 0; k < 5; k++) exp_p[j][k] = '0;
        end
        load_table();
        #12;
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_mem_rd", 32'(mem_rd_a), 0);
        check("rst_mem_addr", 32'(mem_addr_a), 0);
        check("rst_valid", 32'(rec_valid_a), 0);
        check("rst_data", 32'(rec_data_a), 0);
        check("rst_p4", 32'(p4_a), 0);
        @(negedge clock);
        reset_n = 1;
        tick();

        // Plain scan, ready always high
        run_scan(0);

        // Backpressure: four stalled cycles while record 2 is offered
        for (int c = 9; c <= 12; c++) rdy[c] = 0;
        run_scan(0);

        // ID mismatch in slot 3, then a clean scan with extra start pulses
        mem[3] = 11'h155;
        run_scan(0);
        mem[3] = 11'h355;
        st[2] = 1; st[7] = 1; st[16] = 1;
        run_scan(0);

        // Asynchronous reset in the middle of record 2
        sel = 0;
        start = 1;
        tick();
        start = 0;
        rec_ready = 1;
        repeat (7) tick();
        #2 reset_n = 0;
        #1;
        cur_cycle = -1;
        check("arst_busy", 32'(busy_a), 0);
        check("arst_err", 32'(err_a), 0);
        check("arst_mem_rd", 32'(mem_rd_a), 0);
        check("arst_valid", 32'(rec_valid_a), 0);
        check("arst_data", 32'(rec_data_a), 0);
        check("arst_p0", 32'(p0_a), 0);
        check("arst_p1", 32'(p1_a), 0);
        @(negedge clock);
        reset_n = 1;
        rec_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("arst_no_done", 32'(done_a), 0);
        end
        tick();
        for (int j = 0; j < 2; j++) begin
            err_prev[j] = 0;
            for (int k = 0; k < 5; k++) exp_p[j][k] = '0;
        end
        run_scan(0);

        // Address wrap on the base-6 instance
        mem[6] = 11'h0A1; mem[7] = 11'h1B2; mem[0] = 11'h2C3; mem[1] = 11'h3D4; mem[2] = 11'h4E5;
        run_scan(1);

        // Randomized scans: random data/IDs, random ready, random ignored start pulses
        for (int n = 0; n < 8; n++) begin
            bit w;
            w = ($urandom_range(0, 3) == 0);
            load_random(w);
            for (int c = 1; c < CMAX; c++) rdy[c] = (c >= 150) ? 1'b1 : ($urandom_range(0, 9) < 7);
            for (int c = 1; c < 150; c++) st[c] = ($urandom_range(0, 9) == 0);
            // Only pulses up to the done cycle are guaranteed to be dropped.
            build_model(w);
            for (int c = done_c + 1; c < CMAX; c++) st[c] = 0;
            run_scan(w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
